// File: rtl/x86_insn_serializer.sv
// x86_insn_serializer: serializes one pre-resolved x86-64 instruction field set into bytes on a valid/ready stream.
module x86_insn_serializer #(
   parameter int MAX_INSN_LEN = 15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_lock_repeat,
   input  logic [7:0]  in_segment,
   input  logic [7:0]  in_opsize,
   input  logic [7:0]  in_addrsize,
   input  logic [7:0]  in_rex,
   input  logic [23:0] in_opcode,
   input  logic [1:0]  in_opcode_len,
   input  logic        in_modrm_en,
   input  logic [7:0]  in_modrm,
   input  logic        in_sib_en,
   input  logic [7:0]  in_sib,
   input  logic [2:0]  in_disp_len,
   input  logic [31:0] in_disp,
   input  logic [3:0]  in_imm_len,
   input  logic [63:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic        out_first,
   output logic        out_last,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, CHECK, PREFIX, OPCODE, MODRM, SIB, DISP, IMM} state_t;
   state_t state, state_nx, nf;
   logic [7:0]  pfx [5];
   logic [4:0]  pmask;
   logic [23:0] opcode;
   logic [1:0]  opcode_len;
   logic        modrm_en, sib_en;
   logic [7:0]  modrm, sib;
   logic [2:0]  disp_len;
   logic [31:0] disp;
   logic [3:0]  imm_len;
   logic [63:0] imm;
   logic [3:0]  cnt;
   logic [4:0]  pos, len;
   logic [5:0]  len_full;
   logic [2:0]  pidx;
   logic        hs, bad, field_done;
   assign in_ready  = state == IDLE;
   assign out_valid = state >= PREFIX;
   assign hs        = out_valid && out_ready;
   assign out_first = out_valid && pos == 5'd0;
   assign out_last  = out_valid && pos == len - 5'd1;
   assign len_full  = 6'(pmask[0]) + 6'(pmask[1]) + 6'(pmask[2]) + 6'(pmask[3]) + 6'(pmask[4])
                    + 6'(opcode_len) + 6'(modrm_en) + 6'(sib_en) + 6'(disp_len) + 6'(imm_len);
   assign bad = opcode_len == 2'd0 || !(disp_len inside {3'd0, 3'd1, 3'd2, 3'd4})
             || !(imm_len inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8})
             || (sib_en && !modrm_en) || len_full > 6'(MAX_INSN_LEN);
   assign err = state == CHECK && bad;
   // lowest pending slot goes first, so REX (slot 4) always lands right before the opcode
   always_comb begin
      pidx = 3'd0;
      for (int i = 4; i >= 0; i--) if (pmask[i]) pidx = 3'(i);
   end
   always_comb begin
      nf = (state < PREFIX && pmask != 5'd0) ? PREFIX :
           (state < OPCODE)                  ? OPCODE :
           (state < MODRM && modrm_en)       ? MODRM  :
           (state < SIB && sib_en)           ? SIB    :
           (state < DISP && disp_len != 3'd0) ? DISP  :
           (state < IMM && imm_len != 4'd0)  ? IMM    : IDLE;
      field_done = (state == PREFIX) ? (pmask & ~(5'b1 << pidx)) == 5'd0 :
                   (state == OPCODE) ? cnt[1:0] == opcode_len - 2'd1 :
                   (state == DISP)   ? cnt[2:0] == disp_len - 3'd1 :
                   (state == IMM)    ? cnt == imm_len - 4'd1 : 1'b1;
      state_nx = (state == IDLE)  ? (in_valid ? CHECK : IDLE) :
                 (state == CHECK) ? (bad ? IDLE : nf) :
                 (hs && field_done) ? nf : state;
   end
   always_comb begin
      out_byte = 8'd0;
      case (state)
         PREFIX:  out_byte = pfx[pidx];
         OPCODE:  out_byte = 8'(opcode >> {opcode_len - 2'd1 - cnt[1:0], 3'b000});
         MODRM:   out_byte = modrm;
         SIB:     out_byte = sib;
         DISP:    out_byte = 8'(disp >> {cnt[1:0], 3'b000});
         IMM:     out_byte = 8'(imm >> {cnt[2:0], 3'b000});
         default: out_byte = 8'd0;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pfx        <= '{default: 8'd0};
         pmask      <= 5'd0;
         opcode     <= 24'd0;
         opcode_len <= 2'd0;
         modrm_en   <= 1'b0;
         modrm      <= 8'd0;
         sib_en     <= 1'b0;
         sib        <= 8'd0;
         disp_len   <= 3'd0;
         disp       <= 32'd0;
         imm_len    <= 4'd0;
         imm        <= 64'd0;
         cnt        <= 4'd0;
         pos        <= 5'd0;
         len        <= 5'd0;
      end else begin
         if (in_valid && in_ready) begin
            pfx        <= '{in_lock_repeat, in_segment, in_opsize, in_addrsize, in_rex};
            pmask      <= {in_rex != 8'd0, in_addrsize != 8'd0, in_opsize != 8'd0,
                           in_segment != 8'd0, in_lock_repeat != 8'd0};
            opcode     <= in_opcode;
            opcode_len <= in_opcode_len;
            modrm_en   <= in_modrm_en;
            modrm      <= in_modrm;
            sib_en     <= in_sib_en;
            sib        <= in_sib;
            disp_len   <= in_disp_len;
            disp       <= in_disp;
            imm_len    <= in_imm_len;
            imm        <= in_imm;
         end
         if (state == CHECK) begin
            len <= len_full[4:0];
            pos <= 5'd0;
            cnt <= 4'd0;
         end
         if (hs) begin
            pos <= pos + 5'd1;
            cnt <= field_done ? 4'd0 : cnt + 4'd1;
            if (state == PREFIX) pmask[pidx] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_x86_insn_serializer.sv
// tb_x86_insn_serializer: directed and randomized checks of the serializer against a byte-list reference model.
module tb_x86_insn_serializer;
   logic        clk = 1'b0, reset_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [7:0]  in_lock_repeat, in_segment, in_opsize, in_addrsize, in_rex, in_modrm, in_sib;
   logic [23:0] in_opcode;
   logic [1:0]  in_opcode_len;
   logic        in_modrm_en, in_sib_en;
   logic [2:0]  in_disp_len;
   logic [31:0] in_disp;
   logic [3:0]  in_imm_len;
   logic [63:0] in_imm;
   logic        out_valid, out_ready = 1'b0, out_first, out_last, err;
   logic [7:0]  out_byte;

   typedef struct packed {
      logic [7:0] lock, seg, ops, adr, rex;
      logic [23:0] opc;
      logic [1:0] olen;
      logic men;
      logic [7:0] modrm;
      logic sen;
      logic [7:0] sib;
      logic [2:0] dlen;
      logic [31:0] disp;
      logic [3:0] ilen;
      logic [63:0] imm;
   } req_t;

   int checks = 0, fails = 0;
   logic [7:0] exp_q[$];

   x86_insn_serializer dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_lock_repeat(in_lock_repeat), .in_segment(in_segment), .in_opsize(in_opsize),
      .in_addrsize(in_addrsize), .in_rex(in_rex), .in_opcode(in_opcode),
      .in_opcode_len(in_opcode_len), .in_modrm_en(in_modrm_en), .in_modrm(in_modrm),
      .in_sib_en(in_sib_en), .in_sib(in_sib), .in_disp_len(in_disp_len), .in_disp(in_disp),
      .in_imm_len(in_imm_len), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
      .out_byte(out_byte), .out_first(out_first), .out_last(out_last), .err(err));

   always #5 clk = ~clk;

   // Reference: the instruction as an ordered byte list; returns 1 if it must be rejected.
   function automatic bit model(input req_t r);
      int n;
      exp_q.delete();
      if (r.lock != 0) exp_q.push_back(r.lock);
      if (r.seg != 0) exp_q.push_back(r.seg);
      if (r.ops != 0) exp_q.push_back(r.ops);
      if (r.adr != 0) exp_q.push_back(r.adr);
      if (r.rex != 0) exp_q.push_back(r.rex);
      for (int i = int'(r.olen) - 1; i >= 0; i--) exp_q.push_back(r.opc[8*i +: 8]);
      if (r.men) exp_q.push_back(r.modrm);
      if (r.sen) exp_q.push_back(r.sib);
      for (int i = 0; i < int'(r.dlen) && i < 4; i++) exp_q.push_back(r.disp[8*i +: 8]);
      for (int i = 0; i < int'(r.ilen) && i < 8; i++) exp_q.push_back(r.imm[8*i +: 8]);
      n = (r.lock != 0) + (r.seg != 0) + (r.ops != 0) + (r.adr != 0) + (r.rex != 0)
        + int'(r.olen) + int'(r.men) + int'(r.sen) + int'(r.dlen) + int'(r.ilen);
      return r.olen == 0 || !(r.dlen inside {3'd0, 3'd1, 3'd2, 3'd4})
          || !(r.ilen inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd8}) || (r.sen && !r.men) || n > 15;
   endfunction

   function automatic req_t nop();
      req_t r = '0;
      r.opc = 24'h90;
      r.olen = 2'd1;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      logic [2:0] dl[7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd3};
      logic [3:0] il[7] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3};
      r.lock  = $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      r.seg   = $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      r.ops   = $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      r.adr   = $urandom_range(0, 2) == 0 ? 8'($urandom_range(1, 255)) : 8'h00;
      r.rex   = $urandom_range(0, 1) == 0 ? 8'($urandom_range(8'h40, 8'h4F)) : 8'h00;
      r.opc   = 24'($urandom);
      r.olen  = $urandom_range(0, 9) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
      r.men   = 1'($urandom_range(0, 1));
      r.modrm = 8'($urandom);
      r.sen   = $urandom_range(0, 5) == 0 ? 1'b1 : r.men & 1'($urandom_range(0, 1));
      r.sib   = 8'($urandom);
      r.dlen  = dl[$urandom_range(0, 6)];
      r.disp  = $urandom;
      r.ilen  = il[$urandom_range(0, 6)];
      r.imm   = {$urandom, $urandom};
      return r;
   endfunction

   task automatic drive(input req_t r, input logic v);
      in_valid = v;
      in_lock_repeat = r.lock; in_segment = r.seg; in_opsize = r.ops; in_addrsize = r.adr;
      in_rex = r.rex; in_opcode = r.opc; in_opcode_len = r.olen; in_modrm_en = r.men;
      in_modrm = r.modrm; in_sib_en = r.sen; in_sib = r.sib; in_disp_len = r.dlen;
      in_disp = r.disp; in_imm_len = r.ilen; in_imm = r.imm;
   endtask

   // mode: 0 always ready, 1 ready toggling 1,0,1,0..., 2 random ready
   task automatic send(input req_t r, input int mode, input bit hold, input req_t nxt);
      bit e, done = 0, rdy, v, f, l;
      logic [7:0] b;
      logic [7:0] got[$];
      int n = 0, k = 0;
      e = model(r);
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL accept_wait in_ready=%b want 1", in_ready); end
      drive(r, 1'b1);
      @(posedge clk); #1;
      if (hold) drive(nxt, 1'b1); else drive(rand_req(), 1'b0);
      checks++;
      if (err !== e) begin fails++; $display("FAIL err_at_check got %b want %b", err, e); end
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL valid_at_check got %b want 0", out_valid); end
      @(posedge clk); #1;
      if (e) begin
         checks++;
         if (err !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL err_pulse_end err=%b out_valid=%b in_ready=%b want 0 0 1", err, out_valid, in_ready);
         end
         return;
      end
      checks++;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL first_byte_latency out_valid=%b want 1", out_valid); end
      n = 0;
      while (!done && n < 200) begin
         rdy = mode == 0 ? 1'b1 : mode == 1 ? ~k[0] : 1'($urandom_range(0, 1));
         k++;
         out_ready = rdy; v = out_valid; b = out_byte; f = out_first; l = out_last;
         checks++;
         if (v && (f !== (got.size() == 0) || l !== (got.size() == exp_q.size() - 1))) begin
            fails++; $display("FAIL first_last idx=%0d got %b%b want %b%b", got.size(), f, l,
                              got.size() == 0, got.size() == exp_q.size() - 1);
         end
         if (hold) begin
            checks++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
         end
         @(posedge clk); #1; n++;
         if (v && rdy) begin
            got.push_back(b);
            done = got.size() >= exp_q.size();
         end else begin
            checks++;
            if (out_valid !== 1'b1 || out_byte !== b || out_first !== f || out_last !== l) begin
               fails++; $display("FAIL stall_hold v=%b byte=%h f=%b l=%b want 1 %h %b %b",
                                 out_valid, out_byte, out_first, out_last, b, f, l);
            end
         end
      end
      out_ready = 1'b0;
      checks++;
      if (got.size() != exp_q.size()) begin fails++; $display("FAIL byte_count got %0d want %0d", got.size(), exp_q.size()); end
      foreach (got[i]) begin
         checks++;
         if (i < exp_q.size() && got[i] !== exp_q[i]) begin
            fails++; $display("FAIL byte[%0d] got %h want %h", i, got[i], exp_q[i]);
         end
      end
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL bubble out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
      end
   endtask

   function automatic req_t case2();
      req_t r = '0;
      r.rex = 8'h48; r.opc = 24'hB8; r.olen = 2'd1; r.ilen = 4'd8; r.imm = 64'h1122334455667788;
      return r;
   endfunction

   function automatic req_t case3();
      req_t r = '0;
      r.lock = 8'hF0; r.opc = 24'h0FB1; r.olen = 2'd2; r.men = 1'b1; r.modrm = 8'h4C;
      r.sen = 1'b1; r.sib = 8'h24; r.dlen = 3'd1; r.disp = 32'h08;
      return r;
   endfunction

   task automatic test_reset();
      drive(nop(), 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 0 || out_byte !== 0 || out_first !== 0 || out_last !== 0 || err !== 0) begin
         fails++; $display("FAIL reset_outputs v=%b b=%h f=%b l=%b e=%b want all 0", out_valid, out_byte, out_first, out_last, err);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      send(nop(), 0, 0, nop());
      send(case2(), 0, 0, nop());
      send(case3(), 0, 0, nop());
   endtask

   task automatic test_back_to_back();
      send(case2(), 1, 1, nop());
      send(nop(), 0, 0, nop());
   endtask

   task automatic test_errors();
      req_t r = '0;
      r.lock = 8'hF0; r.seg = 8'h2E; r.ops = 8'h66; r.adr = 8'h67; r.rex = 8'h48;
      r.opc = 24'h0F3A0F; r.olen = 2'd3; r.men = 1'b1; r.modrm = 8'h84; r.sen = 1'b1; r.sib = 8'h24;
      r.dlen = 3'd4; r.disp = 32'h12345678; r.ilen = 4'd4; r.imm = 64'hAABBCCDD;
      send(r, 0, 0, nop());
      r.ilen = 4'd1;
      send(r, 2, 0, nop());
      r.ilen = 4'd2;
      send(r, 0, 0, nop());
      r = nop(); r.ilen = 4'd3;
      send(r, 0, 0, nop());
      r = nop(); r.olen = 2'd0;
      send(r, 0, 0, nop());
      r = nop(); r.sen = 1'b1;
      send(r, 0, 0, nop());
      r = nop(); r.dlen = 3'd3;
      send(r, 0, 0, nop());
   endtask

   task automatic test_mid_reset();
      drive(case2(), 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 0 || out_byte !== 0 || out_first !== 0 || out_last !== 0) begin
         fails++; $display("FAIL midreset_outputs v=%b b=%h f=%b l=%b want all 0", out_valid, out_byte, out_first, out_last);
      end
      out_ready = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++; $display("FAIL midreset_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      send(nop(), 0, 0, nop());
   endtask

   task automatic test_random();
      for (int t = 0; t < 60; t++) send(rand_req(), 2, 0, nop());
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_errors();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
